// File: rtl/alu_pkg.sv
// Shared types for the ALU core and its command/result driver.
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_OP2 = 2'b10,
      ALU_OP3 = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } drv_state_e;

endpackage

// File: rtl/ALUCore.sv
// Combinational ALU: signed add/sub with two's-complement overflow, bitwise AND/OR.
module ALUCore
   import alu_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [1:0]   op,
   output logic [W-1:0] s,
   output logic         overflow,
   output logic         zero
);

   always_comb begin
      s        = '0;
      overflow = 1'b0;
      case (alu_op_e'(op))
         ALU_ADD: begin
            s        = a + b;
            overflow = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
         end
         ALU_SUB: begin
            s        = a - b;
            overflow = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
         end
         ALU_OP2: s = a & b;
         ALU_OP3: s = a | b;
         default: s = '0;
      endcase
      zero = (s == '0);
   end

endmodule

// File: rtl/alu_core_driver.sv
// Issues commands to an external ALUCore, captures its outputs after a settle time
// and hands them off with a sequence tag; keeps op/overflow statistics.
module alu_core_driver #(
   parameter int unsigned W      = 4,
   parameter int unsigned SETTLE = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [W-1:0]     cmd_a,
   input  logic [W-1:0]     cmd_b,
   input  logic [1:0]       cmd_op,
   output logic [W-1:0]     alu_a,
   output logic [W-1:0]     alu_b,
   output logic [1:0]       alu_op,
   input  logic [W-1:0]     alu_s,
   input  logic             alu_overflow,
   input  logic             alu_zero,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [W-1:0]     res_s,
   output logic             res_overflow,
   output logic             res_zero,
   output logic [CNT_W-1:0] res_tag,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] ovf_count
);

   localparam int unsigned SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   alu_pkg::drv_state_e state, state_nxt;
   logic [SC_W-1:0]  settle_cnt, settle_cnt_nxt;
   logic [CNT_W-1:0] tag, tag_nxt;
   logic [W-1:0]     alu_a_nxt, alu_b_nxt, res_s_nxt;
   logic [1:0]       alu_op_nxt;
   logic             res_valid_nxt, res_overflow_nxt, res_zero_nxt;
   logic [CNT_W-1:0] res_tag_nxt, op_count_nxt, ovf_count_nxt;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= alu_pkg::IDLE;
         settle_cnt   <= '0;
         tag          <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= '0;
         res_valid    <= 1'b0;
         res_s        <= '0;
         res_overflow <= 1'b0;
         res_zero     <= 1'b0;
         res_tag      <= '0;
         op_count     <= '0;
         ovf_count    <= '0;
      end else begin
         state        <= state_nxt;
         settle_cnt   <= settle_cnt_nxt;
         tag          <= tag_nxt;
         alu_a        <= alu_a_nxt;
         alu_b        <= alu_b_nxt;
         alu_op       <= alu_op_nxt;
         res_valid    <= res_valid_nxt;
         res_s        <= res_s_nxt;
         res_overflow <= res_overflow_nxt;
         res_zero     <= res_zero_nxt;
         res_tag      <= res_tag_nxt;
         op_count     <= op_count_nxt;
         ovf_count    <= ovf_count_nxt;
      end
   end

   // Next-state and next-register logic; cmd_ready follows res_ready in HOLD
   always_comb begin
      state_nxt        = state;
      cmd_ready        = 1'b0;
      settle_cnt_nxt   = settle_cnt;
      tag_nxt          = tag;
      alu_a_nxt        = alu_a;
      alu_b_nxt        = alu_b;
      alu_op_nxt       = alu_op;
      res_valid_nxt    = res_valid;
      res_s_nxt        = res_s;
      res_overflow_nxt = res_overflow;
      res_zero_nxt     = res_zero;
      res_tag_nxt      = res_tag;
      op_count_nxt     = op_count;
      ovf_count_nxt    = ovf_count;

      case (state)
         alu_pkg::IDLE: begin
            cmd_ready = 1'b1;
         end
         alu_pkg::SETTLE: begin
            if (settle_cnt == '0) begin
               res_s_nxt        = alu_s;
               res_overflow_nxt = alu_overflow;
               res_zero_nxt     = alu_zero;
               res_tag_nxt      = tag;
               res_valid_nxt    = 1'b1;
               state_nxt        = alu_pkg::HOLD;
            end else begin
               settle_cnt_nxt = settle_cnt - SC_W'(1);
            end
         end
         alu_pkg::HOLD: begin
            cmd_ready = res_ready;
            if (res_ready) begin
               res_valid_nxt = 1'b0;
               op_count_nxt  = op_count + CNT_W'(1);
               tag_nxt       = tag + CNT_W'(1);
               if (res_overflow && (ovf_count != '1))
                  ovf_count_nxt = ovf_count + CNT_W'(1);
               state_nxt = alu_pkg::IDLE;
            end
         end
         default: state_nxt = alu_pkg::IDLE;
      endcase

      // A command accepted here (IDLE or bypassed from HOLD) starts a new settle window
      if (cmd_valid && cmd_ready) begin
         alu_a_nxt      = cmd_a;
         alu_b_nxt      = cmd_b;
         alu_op_nxt     = cmd_op;
         settle_cnt_nxt = SC_W'(SETTLE - 1);
         state_nxt      = alu_pkg::SETTLE;
      end
   end

endmodule

// File: tb/tb_alu_core_driver.sv
// Bench for alu_core_driver driving an ALUCore; checks against an arithmetic reference model.
module tb_alu_core_driver;

   localparam int unsigned W      = 4;
   localparam int unsigned SETTLE = 1;
   localparam int unsigned CNT_W  = 8;
   localparam int          CMOD   = 2 ** CNT_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [W-1:0]     cmd_a = '0;
   logic [W-1:0]     cmd_b = '0;
   logic [1:0]       cmd_op = '0;
   logic [W-1:0]     alu_a, alu_b, alu_s;
   logic [1:0]       alu_op;
   logic             alu_overflow, alu_zero;
   logic             res_valid;
   logic             res_ready = 1'b1;
   logic [W-1:0]     res_s;
   logic             res_overflow, res_zero;
   logic [CNT_W-1:0] res_tag, op_count, ovf_count;

   int tests = 0;
   int fails = 0;
   int exp_op = 0;
   int exp_ovf = 0;
   int exp_tag = 0;

   always #5 clk = ~clk;

   alu_core_driver #(.W(W), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_s(alu_s), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_s(res_s), .res_overflow(res_overflow), .res_zero(res_zero),
      .res_tag(res_tag), .op_count(op_count), .ovf_count(ovf_count)
   );

   ALUCore #(.W(W)) u_alu (
      .a(alu_a), .b(alu_b), .op(alu_op),
      .s(alu_s), .overflow(alu_overflow), .zero(alu_zero)
   );

   // Reference: 4-bit signed integer arithmetic, overflow when result leaves [-8,7]
   function automatic void model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                                 output logic [3:0] s, output logic v, output logic z);
      int sa, sb, r;
      sa = int'($signed(a));
      sb = int'($signed(b));
      v  = 1'b0;
      case (op)
         2'd0:    r = sa + sb;
         2'd1:    r = sa - sb;
         2'd2:    r = int'(a & b);
         default: r = int'(a | b);
      endcase
      if (op < 2'd2) v = (r > 7) || (r < -8);
      s = r[3:0];
      z = (s == 4'd0);
   endfunction

   function automatic void count_handshake(input logic v);
      exp_op  = (exp_op + 1) % CMOD;
      exp_tag = (exp_tag + 1) % CMOD;
      if (v && exp_ovf < CMOD - 1) exp_ovf = exp_ovf + 1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b1;
      tick(); tick();
      tests++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== '0 || ovf_count !== '0 ||
          res_tag !== '0 || alu_a !== '0 || alu_b !== '0 || alu_op !== '0 || res_s !== '0 ||
          res_overflow !== 1'b0 || res_zero !== 1'b0) begin
         fails++;
         $display("FAIL reset_values got valid=%b rdy=%b opc=%0d ovc=%0d tag=%0d a=%h s=%h want 0,1,0,0,0,0,0",
                  res_valid, cmd_ready, op_count, ovf_count, res_tag, alu_a, res_s);
      end
      rst = 1'b0;
      tick();
      cmd_a = 4'd5; cmd_b = 4'd3; cmd_op = 2'd0; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tests++;
      if (alu_a !== 4'd5 || cmd_ready !== 1'b0 || res_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_pre_settle got a=%h rdy=%b valid=%b want 5,0,0", alu_a, cmd_ready, res_valid);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_a !== '0 || op_count !== '0) begin
         fails++;
         $display("FAIL reset_mid_settle got valid=%b rdy=%b a=%h opc=%0d want 0,1,0,0",
                  res_valid, cmd_ready, alu_a, op_count);
      end
      tick();
      rst = 1'b0;
      repeat (3) tick();
      tests++;
      if (res_valid !== 1'b0 || op_count !== '0 || res_tag !== '0) begin
         fails++;
         $display("FAIL reset_no_result got valid=%b opc=%0d tag=%0d want 0,0,0", res_valid, op_count, res_tag);
      end
      exp_op = 0; exp_ovf = 0; exp_tag = 0;
   endtask

   task automatic test_single(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                              input string name);
      logic [3:0] es;
      logic       ev, ez;
      model(a, b, op, es, ev, ez);
      res_ready = 1'b1;
      tests++;
      if (cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s_idle_ready got %b want 1", name, cmd_ready);
      end
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tests++;
      if (res_valid !== 1'b0 || alu_a !== a || alu_b !== b || alu_op !== op) begin
         fails++;
         $display("FAIL %s_drive got valid=%b a=%h b=%h op=%0d want 0,%h,%h,%0d",
                  name, res_valid, alu_a, alu_b, alu_op, a, b, op);
      end
      tick();
      tests++;
      if (res_valid !== 1'b1 || res_s !== es || res_overflow !== ev || res_zero !== ez ||
          res_tag !== CNT_W'(exp_tag)) begin
         fails++;
         $display("FAIL %s_result got valid=%b s=%h v=%b z=%b tag=%0d want 1,%h,%b,%b,%0d",
                  name, res_valid, res_s, res_overflow, res_zero, res_tag, es, ev, ez, exp_tag);
      end
      tick();
      count_handshake(ev);
      tests++;
      if (res_valid !== 1'b0 || op_count !== CNT_W'(exp_op) || ovf_count !== CNT_W'(exp_ovf)) begin
         fails++;
         $display("FAIL %s_counts got valid=%b opc=%0d ovc=%0d want 0,%0d,%0d",
                  name, res_valid, op_count, ovf_count, exp_op, exp_ovf);
      end
   endtask

   task automatic test_directed;
      test_single(4'b0011, 4'b0010, 2'd0, "add_small");
      test_single(4'b0110, 4'b0111, 2'd0, "add_ovf");
      test_single(4'b0011, 4'b0011, 2'd1, "sub_zero");
   endtask

   task automatic test_random;
      for (int i = 0; i < 24; i++)
         test_single(4'($urandom), 4'($urandom), 2'($urandom_range(0, 3)), "rand");
   endtask

   task automatic test_backpressure;
      logic [3:0] es, es2;
      logic       ev, ez, ev2, ez2;
      logic [3:0] a2, b2;
      int         opc0;
      a2 = 4'($urandom); b2 = 4'($urandom);
      model(4'b1000, 4'b0001, 2'd1, es, ev, ez);
      model(a2, b2, 2'd0, es2, ev2, ez2);
      res_ready = 1'b0;
      cmd_a = 4'b1000; cmd_b = 4'b0001; cmd_op = 2'd1; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      opc0 = exp_op;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (res_valid !== 1'b1 || res_s !== es || res_overflow !== ev || res_zero !== ez ||
             cmd_ready !== 1'b0 || op_count !== CNT_W'(opc0) || res_tag !== CNT_W'(exp_tag)) begin
            fails++;
            $display("FAIL bp_hold[%0d] got valid=%b s=%h v=%b rdy=%b opc=%0d want 1,%h,%b,0,%0d",
                     i, res_valid, res_s, res_overflow, cmd_ready, op_count, es, ev, opc0);
         end
         tick();
      end
      res_ready = 1'b1;
      cmd_a = a2; cmd_b = b2; cmd_op = 2'd0; cmd_valid = 1'b1;
      #1;
      tests++;
      if (cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_bypass_ready got %b want 1", cmd_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      count_handshake(ev);
      tests++;
      if (res_valid !== 1'b0 || alu_a !== a2 || alu_b !== b2 || cmd_ready !== 1'b0 ||
          op_count !== CNT_W'(exp_op) || ovf_count !== CNT_W'(exp_ovf)) begin
         fails++;
         $display("FAIL bp_direct_settle got valid=%b a=%h rdy=%b opc=%0d ovc=%0d want 0,%h,0,%0d,%0d",
                  res_valid, alu_a, cmd_ready, op_count, ovf_count, a2, exp_op, exp_ovf);
      end
      tick();
      tests++;
      if (res_valid !== 1'b1 || res_s !== es2 || res_overflow !== ev2 || res_tag !== CNT_W'(exp_tag)) begin
         fails++;
         $display("FAIL bp_second_result got valid=%b s=%h v=%b tag=%0d want 1,%h,%b,%0d",
                  res_valid, res_s, res_overflow, res_tag, es2, ev2, exp_tag);
      end
      tick();
      count_handshake(ev2);
   endtask

   task automatic test_back_to_back;
      int         total, issued, done, cyc;
      logic [3:0] es;
      logic       ev, ez;
      total = CMOD + 3;
      rst = 1'b1; tick(); rst = 1'b0; tick();
      exp_op = 0; exp_ovf = 0; exp_tag = 0;
      model(4'b0111, 4'b0111, 2'd0, es, ev, ez);
      issued = 0; done = 0; cyc = 0;
      res_ready = 1'b1;
      cmd_a = 4'b0111; cmd_b = 4'b0111; cmd_op = 2'd0; cmd_valid = 1'b1;
      while (done < total && cyc < 4 * total) begin
         @(negedge clk);
         cyc++;
         if (res_valid) begin
            tests++;
            if (res_s !== es || res_overflow !== ev || res_zero !== ez || res_tag !== CNT_W'(exp_tag)) begin
               fails++;
               $display("FAIL stream[%0d] got s=%h v=%b z=%b tag=%0d want %h,%b,%b,%0d",
                        done, res_s, res_overflow, res_zero, res_tag, es, ev, ez, exp_tag);
            end
            done++;
            count_handshake(ev);
         end
         if (cmd_valid && cmd_ready) issued++;
         @(posedge clk); #1;
         cmd_valid = (issued < total);
      end
      tests++;
      if (done != total || cyc != 2 * total + 1) begin
         fails++;
         $display("FAIL stream_throughput got %0d results in %0d cycles want %0d in %0d",
                  done, cyc, total, 2 * total + 1);
      end
      tests++;
      if (op_count !== 8'd3 || ovf_count !== 8'hFF || op_count !== CNT_W'(exp_op) ||
          ovf_count !== CNT_W'(exp_ovf)) begin
         fails++;
         $display("FAIL stream_counters got opc=%0d ovc=%h want 3,ff", op_count, ovf_count);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
